// File: rtl/vga_render_pipe.sv
// Two-stage pixel colouriser with per-frame player/obstacle collision detection.
// Latency: rgb_valid/rgb/frame_done follow pix_valid by exactly 2 cycles; collision updates 1 cycle after frame_done.
// Backpressure: none; accepts one pixel every cycle, bubbles in pix_valid pass through as bubbles.
//
// Ports:
//   clk, rst                       pixel clock, synchronous active-high reset
//   pix_valid, pix_x, pix_y        coordinate stream from the timing block
//   gamemode, player_y             00 start, 01 playing, 10 paused, 11 game over; player top edge
//   obs_left/right/up/down         packed per-slot obstacle edges (right/down exclusive)
//   rgb_valid, rgb                 12-bit {R,G,B}; rgb holds while rgb_valid is low
//   frame_done                     1-cycle pulse alongside the last pixel of a frame
//   collision                      overlap flag for the most recently completed frame
module vga_render_pipe #(
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int N_OBS    = 10,
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int PLAYER_X = 100,
    parameter int PLAYER_W = 20,
    parameter int PLAYER_H = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pix_valid,
    input  logic [X_W-1:0]         pix_x,
    input  logic [Y_W-1:0]         pix_y,
    input  logic [1:0]             gamemode,
    input  logic [Y_W-1:0]         player_y,
    input  logic [N_OBS*X_W-1:0]   obs_left,
    input  logic [N_OBS*X_W-1:0]   obs_right,
    input  logic [N_OBS*Y_W-1:0]   obs_up,
    input  logic [N_OBS*Y_W-1:0]   obs_down,
    output logic                   rgb_valid,
    output logic [11:0]            rgb,
    output logic                   frame_done,
    output logic                   collision
);

    // All range limits carry one extra bit so edge + size never wraps.
    localparam logic [X_W:0]   PX_LO  = (X_W+1)'(PLAYER_X);
    localparam logic [X_W:0]   PX_HI  = (X_W+1)'(PLAYER_X + PLAYER_W);
    localparam logic [Y_W:0]   PH     = (Y_W+1)'(PLAYER_H);
    localparam logic [X_W:0]   X_LIM  = (X_W+1)'(H_RES);
    localparam logic [Y_W:0]   Y_LIM  = (Y_W+1)'(V_RES);
    localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

    localparam logic [11:0] C_BLACK  = 12'h000;
    localparam logic [11:0] C_BLUE   = 12'h00F;
    localparam logic [11:0] C_RED    = 12'hF00;
    localparam logic [11:0] C_YELLOW = 12'hFF0;
    localparam logic [11:0] C_GREEN  = 12'h0F0;

    typedef struct packed {
        logic             vld;
        logic [1:0]       mode;
        logic             in_player;
        logic [N_OBS-1:0] hit;
        logic             oor;
        logic             last;
    } s1_t;

    s1_t s1_d, s1_q;

    logic [X_W:0] x_ext;
    logic [Y_W:0] y_ext;
    logic [Y_W:0] py_lo;
    logic [Y_W:0] py_hi;

    // Stage 1: box membership and frame-position flags.
    always_comb begin
        s1_d  = '0;
        x_ext = {1'b0, pix_x};
        y_ext = {1'b0, pix_y};
        py_lo = {1'b0, player_y};
        py_hi = py_lo + PH;

        s1_d.vld       = pix_valid;
        s1_d.mode      = gamemode;
        s1_d.in_player = (x_ext >= PX_LO) && (x_ext < PX_HI) &&
                         (y_ext >= py_lo) && (y_ext < py_hi);
        // A slot with left>=right or up>=down can never satisfy both
        // half-open tests, so disabled slots need no separate check.
        for (int i = 0; i < N_OBS; i++) begin
            s1_d.hit[i] = (pix_x >= obs_left[i*X_W +: X_W]) &&
                          (pix_x <  obs_right[i*X_W +: X_W]) &&
                          (pix_y >= obs_up[i*Y_W +: Y_W]) &&
                          (pix_y <  obs_down[i*Y_W +: Y_W]);
        end
        s1_d.oor  = (x_ext >= X_LIM) || (y_ext >= Y_LIM);
        s1_d.last = (pix_x == X_LAST) && (pix_y == Y_LAST);
    end

    logic        rgb_vld_d, rgb_vld_q;
    logic [11:0] rgb_d, rgb_q;
    logic        frame_done_d, frame_done_q;
    logic        ovl_d, ovl_q;
    logic        acc_d, acc_q;
    logic        collision_d, collision_q;

    logic        obs_any;
    logic [11:0] play_rgb;
    logic [11:0] dim_rgb;
    logic [11:0] mux_rgb;

    // Stage 2: colour mux, output registers and the frame accumulator.
    always_comb begin
        obs_any = |s1_q.hit;

        if (s1_q.in_player && obs_any) begin
            play_rgb = C_RED;
        end else if (s1_q.in_player) begin
            play_rgb = C_YELLOW;
        end else if (obs_any) begin
            play_rgb = C_GREEN;
        end else begin
            play_rgb = C_BLACK;
        end

        // Paused view halves every nibble of the play colour.
        dim_rgb = {1'b0, play_rgb[11:9], 1'b0, play_rgb[7:5], 1'b0, play_rgb[3:1]};

        if (s1_q.oor) begin
            mux_rgb = C_BLACK;
        end else begin
            case (s1_q.mode)
                2'b00:   mux_rgb = C_BLUE;
                2'b01:   mux_rgb = play_rgb;
                2'b10:   mux_rgb = dim_rgb;
                default: mux_rgb = C_RED;
            endcase
        end

        rgb_vld_d    = s1_q.vld;
        rgb_d        = s1_q.vld ? mux_rgb : rgb_q;
        frame_done_d = s1_q.vld && s1_q.last;
        ovl_d        = s1_q.vld && s1_q.in_player && obs_any &&
                       (s1_q.mode == 2'b01) && !s1_q.oor;

        // The overlap and frame end of the pixel now on the outputs are
        // folded in on the following edge, so collision trails frame_done
        // by one cycle and the last pixel's own overlap still counts.
        acc_d       = acc_q;
        collision_d = collision_q;
        if (frame_done_q) begin
            collision_d = acc_q || ovl_q;
            acc_d       = 1'b0;
        end else if (ovl_q) begin
            acc_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q         <= '0;
            rgb_vld_q    <= 1'b0;
            rgb_q        <= '0;
            frame_done_q <= 1'b0;
            ovl_q        <= 1'b0;
            acc_q        <= 1'b0;
            collision_q  <= 1'b0;
        end else begin
            s1_q         <= s1_d;
            rgb_vld_q    <= rgb_vld_d;
            rgb_q        <= rgb_d;
            frame_done_q <= frame_done_d;
            ovl_q        <= ovl_d;
            acc_q        <= acc_d;
            collision_q  <= collision_d;
        end
    end

    assign rgb_valid  = rgb_vld_q;
    assign rgb        = rgb_q;
    assign frame_done = frame_done_q;
    assign collision  = collision_q;

endmodule

// File: tb/tb_vga_render_pipe.sv
// Bench for vga_render_pipe: constant vectors, frame sweeps and random traffic.
// Latency: outputs compared half a cycle after each edge against a 2-deep expectation queue.
// Backpressure: none; the bench drives one slot per cycle, valid or bubble.
module tb_vga_render_pipe;

    localparam int N  = 10;
    localparam int XW = 10;
    localparam int YW = 9;

    logic              clk = 1'b0;
    logic              rst;
    logic              pix_valid;
    logic [XW-1:0]     pix_x;
    logic [YW-1:0]     pix_y;
    logic [1:0]        gamemode;
    logic [YW-1:0]     player_y;
    logic [N*XW-1:0]   obs_left;
    logic [N*XW-1:0]   obs_right;
    logic [N*YW-1:0]   obs_up;
    logic [N*YW-1:0]   obs_down;
    logic              rgb_valid;
    logic [11:0]       rgb;
    logic              frame_done;
    logic              collision;

    always #5 clk = ~clk;

    vga_render_pipe #(
        .H_RES(640), .V_RES(480), .N_OBS(N), .X_W(XW), .Y_W(YW),
        .PLAYER_X(100), .PLAYER_W(20), .PLAYER_H(20)
    ) dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .gamemode(gamemode), .player_y(player_y),
        .obs_left(obs_left), .obs_right(obs_right), .obs_up(obs_up), .obs_down(obs_down),
        .rgb_valid(rgb_valid), .rgb(rgb), .frame_done(frame_done), .collision(collision)
    );

    // Obstacle edges as plain integers; packed onto the DUT ports each step.
    int ol[N], orr[N], ou[N], od[N];

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          vld;
        logic [11:0] rgb;
        bit          last;
        bit          ovl;
        bit          has_c;
        logic [11:0] c_rgb;
    } exp_t;

    exp_t        pipe_q[$];
    logic [11:0] held_rgb;
    bit          m_acc;
    bit          m_col;
    int          fd_count;
    int          gy_count;
    bit          last_vld_obs;

    typedef struct {
        int          x;
        int          y;
        int          mode;
        int          py;
        int          scen;
        logic [11:0] exp;
    } vec_t;

    vec_t vt[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, act, want);
        end
    endtask

    // Reference colour/overlap from the box rules with plain integer arithmetic.
    function automatic void m_eval(input int x, input int y, input int mode, input int py,
                                   output logic [11:0] c, output bit ov);
        bit hit;
        bit inp;
        bit oor;
        logic [11:0] play;
        int r, g, b;
        hit = 0;
        for (int i = 0; i < N; i++)
            if (x >= ol[i] && x < orr[i] && y >= ou[i] && y < od[i]) hit = 1;
        inp = (x >= 100) && (x < 120) && (y >= py) && (y < py + 20);
        oor = (x >= 640) || (y >= 480);
        if (inp && hit)  play = 12'hF00;
        else if (inp)    play = 12'hFF0;
        else if (hit)    play = 12'h0F0;
        else             play = 12'h000;
        ov = !oor && mode == 1 && inp && hit;
        r = int'(play[11:8]) / 2;
        g = int'(play[7:4]) / 2;
        b = int'(play[3:0]) / 2;
        if (oor)            c = 12'h000;
        else if (mode == 0) c = 12'h00F;
        else if (mode == 3) c = 12'hF00;
        else if (mode == 1) c = play;
        else                c = {4'(r), 4'(g), 4'(b)};
    endfunction

    task automatic set_sentinels();
        for (int i = 0; i < N; i++) begin
            ol[i] = 1023; orr[i] = 1023; ou[i] = 511; od[i] = 511;
        end
    endtask

    task automatic set_scen(input int s);
        set_sentinels();
        if (s == 1) begin
            ol[0] = 20;  orr[0] = 70;  ou[0] = 41;  od[0] = 71;
            ol[1] = 120; orr[1] = 170; ou[1] = 51;  od[1] = 81;
        end else if (s == 2) begin
            ol[0] = 90;  orr[0] = 130; ou[0] = 190; od[0] = 230;
        end
    endtask

    // One cycle: check what the DUT shows now, then present the next slot.
    task automatic step(input bit v, input int x, input int y, input int mode, input int py,
                        input bit hc, input logic [11:0] crgb);
        exp_t e;
        exp_t n;
        @(negedge clk);
        e = pipe_q.pop_front();
        check("rgb_valid", rgb_valid, e.vld);
        if (e.vld) held_rgb = e.rgb;
        check("rgb", rgb, held_rgb);
        if (e.vld && e.has_c) check("rgb_vector", rgb, e.c_rgb);
        check("frame_done", frame_done, e.vld && e.last);
        check("collision", collision, m_col);
        if (frame_done) fd_count++;
        if (rgb_valid && (rgb == 12'h0F0 || rgb == 12'hFF0)) gy_count++;
        last_vld_obs = rgb_valid;
        if (e.vld && e.last) begin
            m_col = m_acc || e.ovl;
            m_acc = 0;
        end else if (e.vld && e.ovl) begin
            m_acc = 1;
        end

        pix_valid = v;
        pix_x     = 10'(x);
        pix_y     = 9'(y);
        gamemode  = 2'(mode);
        player_y  = 9'(py);
        for (int i = 0; i < N; i++) begin
            obs_left[i*XW +: XW]  = 10'(ol[i]);
            obs_right[i*XW +: XW] = 10'(orr[i]);
            obs_up[i*YW +: YW]    = 9'(ou[i]);
            obs_down[i*YW +: YW]  = 9'(od[i]);
        end
        n.vld   = v;
        n.rgb   = 12'h000;
        n.ovl   = 0;
        if (v) m_eval(x, y, mode, py, n.rgb, n.ovl);
        n.last  = v && x == 639 && y == 479;
        n.has_c = hc;
        n.c_rgb = crgb;
        pipe_q.push_back(n);
    endtask

    task automatic idle(input int cnt, input int mode, input int py);
        for (int k = 0; k < cnt; k++)
            step(0, int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)), mode, py, 0, 12'h000);
    endtask

    // Reset for one cycle while a pixel is being presented; everything in flight is lost.
    task automatic do_reset(input int x, input int y, input int mode, input int py);
        exp_t z;
        @(negedge clk);
        rst = 1; pix_valid = 1; pix_x = 10'(x); pix_y = 9'(y);
        gamemode = 2'(mode); player_y = 9'(py);
        @(negedge clk);
        rst = 0; pix_valid = 0;
        check("rst_rgb_valid", rgb_valid, 1'b0);
        check("rst_rgb", rgb, 12'h000);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_collision", collision, 1'b0);
        pipe_q.delete();
        z = '{0, 12'h000, 0, 0, 0, 12'h000};
        pipe_q.push_back(z);
        pipe_q.push_back(z);
        held_rgb = 12'h000;
        m_col = 0;
        m_acc = 0;
    endtask

    // Sparse raster from (x0,y0) to (x1,y1): coarse grid, dense around the
    // player column near its rows and the top of the screen, random extras and bubbles.
    task automatic sweep(input int y0, input int x0, input int y1, input int x1,
                         input int mode, input int py);
        bit dense;
        bit row;
        bit inc;
        for (int y = y0; y <= y1; y++) begin
            dense = (y < 25) || (y >= py - 2 && y <= py + 22);
            row   = (y % 8 == 0) || dense || y == y0 || y == y1;
            if (row) begin
                for (int x = 0; x < 640; x++) begin
                    if (y == y0 && x < x0) continue;
                    if (y == y1 && x > x1) continue;
                    inc = (x % 128 == 0) || x == 639 || (dense && x >= 88 && x <= 132) ||
                          ($urandom_range(0, 199) == 0);
                    if (inc) begin
                        if ($urandom_range(0, 15) == 0) idle(1, mode, py);
                        step(1, x, y, mode, py, 0, 12'h000);
                    end
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] seen;
        logic [6:0] exp_pat;
        int x, y, py, mode;

        vt[0]  = '{20,  41,  1, 200, 1, 12'h0F0};
        vt[1]  = '{69,  70,  1, 200, 1, 12'h0F0};
        vt[2]  = '{70,  41,  1, 200, 1, 12'h000};
        vt[3]  = '{71,  41,  1, 200, 1, 12'h000};
        vt[4]  = '{100, 200, 1, 200, 1, 12'hFF0};
        vt[5]  = '{119, 219, 1, 200, 1, 12'hFF0};
        vt[6]  = '{120, 200, 1, 200, 1, 12'h000};
        vt[7]  = '{125, 60,  1, 200, 1, 12'h0F0};
        vt[8]  = '{100, 200, 1, 200, 2, 12'hF00};
        vt[9]  = '{100, 200, 2, 200, 2, 12'h700};
        vt[10] = '{100, 200, 0, 200, 2, 12'h00F};
        vt[11] = '{100, 200, 3, 200, 2, 12'hF00};
        vt[12] = '{700, 200, 0, 200, 2, 12'h000};
        vt[13] = '{119, 220, 1, 200, 1, 12'h000};

        rst = 1; pix_valid = 0; pix_x = '0; pix_y = '0; gamemode = '0; player_y = '0;
        obs_left = '0; obs_right = '0; obs_up = '0; obs_down = '0;
        fd_count = 0; gy_count = 0;
        set_sentinels();
        repeat (3) @(negedge clk);
        do_reset(0, 0, 0, 0);

        // Constant vectors, each followed by a bubble so the +1 slot is seen empty.
        for (int k = 0; k < 14; k++) begin
            set_scen(vt[k].scen);
            step(1, vt[k].x, vt[k].y, vt[k].mode, vt[k].py, 1, vt[k].exp);
            idle(1, vt[k].mode, vt[k].py);
        end
        idle(2, 1, 200);
        do_reset(0, 0, 1, 200);

        // Overlapping frame, then paused, overlapping again, then obstacle moved away.
        set_scen(2);
        fd_count = 0;
        sweep(0, 0, 479, 639, 1, 200);
        idle(3, 1, 200);
        check("frameA_done_count", fd_count, 1);
        check("frameA_collision", collision, 1'b1);

        sweep(0, 0, 479, 639, 2, 200);
        idle(3, 2, 200);
        check("paused_collision", collision, 1'b0);

        sweep(0, 0, 479, 639, 1, 200);
        idle(3, 1, 200);
        check("frameA2_collision", collision, 1'b1);

        ol[0] = 400; orr[0] = 450; ou[0] = 300; od[0] = 350;
        sweep(0, 0, 479, 639, 1, 200);
        idle(3, 1, 200);
        check("moved_collision", collision, 1'b0);

        // Bubbles carrying overlapping coordinates must not touch the accumulator.
        set_scen(2);
        idle(2, 1, 200);
        step(1, 20, 20, 1, 200, 1, 12'h000);
        seen[0] = last_vld_obs;
        step(0, 100, 200, 1, 200, 0, 12'h000);
        seen[1] = last_vld_obs;
        step(0, 105, 205, 1, 200, 0, 12'h000);
        seen[2] = last_vld_obs;
        step(1, 400, 100, 1, 200, 1, 12'h000);
        seen[3] = last_vld_obs;
        step(1, 639, 479, 1, 200, 1, 12'h000);
        seen[4] = last_vld_obs;
        step(0, 110, 210, 1, 200, 0, 12'h000);
        seen[5] = last_vld_obs;
        step(0, 111, 211, 1, 200, 0, 12'h000);
        seen[6] = last_vld_obs;
        exp_pat = 7'b1100100;
        check("bubble_pattern", seen, exp_pat);
        idle(1, 1, 200);
        check("bubble_collision", collision, 1'b0);

        // All slots disabled, player at the bottom edge: nothing green or yellow anywhere.
        set_sentinels();
        gy_count = 0;
        sweep(0, 0, 479, 639, 1, 511);
        idle(3, 1, 511);
        check("sentinel_colour_count", gy_count, 0);

        // Reset mid-frame after the overlap rows; the resumed frame must report clean.
        set_scen(2);
        sweep(0, 0, 479, 639, 1, 200);
        idle(3, 1, 200);
        check("pre_reset_collision", collision, 1'b1);
        sweep(0, 0, 240, 299, 1, 200);
        do_reset(300, 240, 1, 200);
        fd_count = 0;
        sweep(240, 301, 479, 639, 1, 200);
        idle(3, 1, 200);
        check("post_reset_done_count", fd_count, 1);
        check("post_reset_collision", collision, 1'b0);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            if (k % 64 == 0) begin
                for (int i = 0; i < N; i++) begin
                    ol[i]  = int'($urandom_range(0, 700));
                    orr[i] = int'($urandom_range(0, 1023));
                    ou[i]  = int'($urandom_range(0, 480));
                    od[i]  = int'($urandom_range(0, 511));
                end
            end
            py   = int'($urandom_range(0, 511));
            mode = int'($urandom_range(0, 3));
            x    = $urandom_range(0, 1) ? int'($urandom_range(80, 140)) : int'($urandom_range(0, 1023));
            y    = $urandom_range(0, 1) ? py + int'($urandom_range(0, 24)) - 2 : int'($urandom_range(0, 511));
            if (y < 0)   y = 0;
            if (y > 511) y = 511;
            if ($urandom_range(0, 99) == 0) begin
                x = 639; y = 479;
            end
            step(bit'($urandom_range(0, 3) != 0), x, y, mode, py, 0, 12'h000);
        end
        idle(3, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
